// File: rtl/mips_mem_bus_arbiter.sv
// mips_mem_bus_arbiter
//   Shares the CPU's single Avalon-style memory master port between the
//   instruction-fetch requester (F) and the load/store requester (D).
//   It picks a winner in IDLE and registers that requester's command onto the
//   bus. The command is held through waitrequest. Readdata returns to the
//   owner with a one-cycle ack. A watchdog aborts a transfer that stays
//   stalled for too long.
//
// Parameters
//   TIMEOUT_CYCLES  max consecutive waitrequest=1 cycles in BUS before abort
//                   (0 disables the watchdog)
//   CNT_W           watchdog counter width, must hold TIMEOUT_CYCLES
//
// Build option
//   ARB_ROUND_ROBIN_EN  defined: on contention grant the side not served last.
//                       undefined: fixed priority, D wins over F.
//
// Ports
//   clk, reset                     clock, asynchronous active-low reset
//   f_req, f_addr, f_ack           fetch request / word address / done pulse
//   d_req, d_write, d_addr,
//   d_wdata, d_byteenable, d_ack   data request / command fields / done pulse
//   rdata, err                     returned read data and abort flag (valid with ack)
//   waitrequest, readdata          bus stall and bus read data
//   address, writedata,
//   byteenable, read, write        registered bus command

module mips_mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_ack,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic        d_ack,
  output logic [31:0] rdata,
  output logic        err,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [31:0] address,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  output logic        read,
  output logic        write
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam bit             WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic               r_owner_d;    // 1 = D owns the current transfer
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_address;
  logic [31:0]        r_writedata;
  logic [3:0]         r_byteenable;
  logic               r_read;
  logic               r_write;
  logic [31:0]        r_rdata;
  logic               r_err;

  logic               w_any_req;
  logic               w_grant_d;
  logic               w_timeout;

  assign w_any_req = f_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers the side granted most recently. After reset it reads as F, so
  // the first contended grant goes to D.
  logic r_rr_d;

  assign w_grant_d = d_req & (~f_req | ~r_rr_d);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_d <= 1'b0;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_rr_d <= w_grant_d;
    end
  end
`else
  // D wins ties, so a load/store completes before the next fetch.
  assign w_grant_d = d_req;
`endif

  // The abort fires on the last permitted stalled cycle. Combined with the
  // counter clearing on BUS entry, this allows exactly TIMEOUT_CYCLES stalled
  // BUS cycles.
  assign w_timeout = WD_EN && (r_cnt == TO_LAST) && waitrequest;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next_state = S_BUS;
      S_BUS:   if (!waitrequest || w_timeout) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output logic: the ack is simply "in DONE" qualified by the owner.
  // It therefore drops together with the state on asynchronous reset.
  always_comb begin
    f_ack = 1'b0;
    d_ack = 1'b0;
    if (r_state == S_DONE) begin
      f_ack = ~r_owner_d;
      d_ack =  r_owner_d;
    end
  end

  // Bus command, captured read data, error flag and watchdog counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner_d    <= 1'b0;
      r_cnt        <= '0;
      r_address    <= '0;
      r_writedata  <= '0;
      r_byteenable <= '0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_read  <= 1'b0;
          r_write <= 1'b0;
          if (w_any_req) begin
            r_owner_d <= w_grant_d;
            r_cnt     <= '0;
            if (w_grant_d) begin
              r_address    <= d_addr;
              r_writedata  <= d_wdata;
              r_byteenable <= d_byteenable;
              r_read       <= ~d_write;
              r_write      <= d_write;
            end else begin
              r_address    <= f_addr;
              r_writedata  <= '0;
              r_byteenable <= 4'b1111;
              r_read       <= 1'b1;
            end
          end
        end
        S_BUS: begin
          if (w_timeout) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b1;
          end else if (waitrequest) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            // A completed store returns zero rather than bus noise.
            r_rdata <= r_read ? readdata : 32'd0;
          end
        end
        S_DONE: begin
          r_err <= 1'b0;
        end
        default: begin
          r_read  <= 1'b0;
          r_write <= 1'b0;
        end
      endcase
    end
  end

  assign address    = r_address;
  assign writedata  = r_writedata;
  assign byteenable = r_byteenable;
  assign read       = r_read;
  assign write      = r_write;
  assign rdata      = r_rdata;
  assign err        = r_err;

endmodule

// File: tb/tb_mips_mem_bus_arbiter.sv
// Testbench for mips_mem_bus_arbiter. Single transfers come from a vector
// table. Contention, back-to-back and mid-transfer reset are hand-written
// sequences. Every ack is matched against a scoreboard queue of expected
// {owner, rdata, err}.
module tb_mips_mem_bus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_ack;
  logic        d_req;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byteenable;
  logic        d_ack;
  logic [31:0] rdata;
  logic        err;
  logic        waitrequest;
  logic [31:0] readdata;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    bit          err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          is_d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          wait_n;     // number of waitrequest=1 cycles before release
    logic [31:0] bus_rdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;
  vec_t vecs[7];

  bit last_d = 1'b0;  // model of the arbiter's "last served" side

  mips_mem_bus_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(9)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteenable(d_byteenable), .d_ack(d_ack),
    .rdata(rdata), .err(err),
    .waitrequest(waitrequest), .readdata(readdata),
    .address(address), .writedata(writedata), .byteenable(byteenable),
    .read(read), .write(write)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every ack must match the oldest expected entry.
  always @(negedge clk) begin
    if (f_ack || d_ack) begin
      n_cmp++;
      if (f_ack && d_ack) begin
        n_fail++;
        $display("FAIL ack_both: f_ack=1 d_ack=1, expected one (t=%0t)", $time);
      end else if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL ack_unexpected: f_ack=%0b d_ack=%0b, expected none (t=%0t)",
                 f_ack, d_ack, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (d_ack !== e.is_d || rdata !== e.rdata || err !== e.err) begin
          n_fail++;
          $display("FAIL ack_sb: got d_ack=%0b rdata=%h err=%0b, expected d_ack=%0b rdata=%h err=%0b (t=%0t)",
                   d_ack, rdata, err, e.is_d, e.rdata, e.err, $time);
        end
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    int   n_bus;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    logic        e_rd, e_wr;
    string       tag;
    tag    = $sformatf("vec%0d", idx);
    e_rd   = v.is_d ? !v.wr : 1'b1;
    e_wr   = v.is_d & v.wr;
    e_addr = v.addr;
    e_wd   = v.is_d ? v.wdata : 32'd0;
    e_be   = v.is_d ? v.be : 4'b1111;
    n_bus  = (v.wait_n >= TO) ? TO : v.wait_n + 1;
    // IDLE cycle: present the request
    step();
    if (v.is_d) begin
      d_req = 1'b1; d_write = v.wr; d_addr = v.addr; d_wdata = v.wdata; d_byteenable = v.be;
    end else begin
      f_req = 1'b1; f_addr = v.addr;
    end
    waitrequest = 1'b1;
    readdata    = 32'hDEAD0000;
    e.is_d = v.is_d; e.rdata = v.exp_rdata; e.err = v.exp_err;
    sb.push_back(e);
    @(negedge clk);
    chk({tag, "_idle_rw"}, {30'd0, read, write}, 32'd0);
    chk({tag, "_idle_err"}, {31'd0, err}, 32'd0);
    // BUS cycles
    for (int k = 0; k < n_bus; k++) begin
      step();
      waitrequest = (k < v.wait_n);
      readdata    = waitrequest ? (32'hDEAD0000 | k) : v.bus_rdata;
      @(negedge clk);
      chk({tag, "_rw"}, {30'd0, read, write}, {30'd0, e_rd, e_wr});
      chk({tag, "_addr"}, address, e_addr);
      chk({tag, "_wdata"}, writedata, e_wd);
      chk({tag, "_be"}, {28'd0, byteenable}, {28'd0, e_be});
    end
    // DONE cycle
    step();
    f_req = 1'b0; d_req = 1'b0; waitrequest = 1'b0;
    @(negedge clk);
    chk({tag, "_ack"}, {30'd0, f_ack, d_ack}, v.is_d ? 32'd1 : 32'd2);
    chk({tag, "_rdata"}, rdata, v.exp_rdata);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, v.exp_err});
    chk({tag, "_done_rw"}, {30'd0, read, write}, 32'd0);
    last_d = v.is_d;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    bit   exp_d;
    //            is_d wr  addr          wdata         be       wait bus_rdata     exp_rdata     err
    vecs[0] = '{1'b0, 1'b0, 32'hBFC00000, 32'h0,        4'b0000, 0,  32'h24020005, 32'h24020005, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h00001000, 32'hDEADBEEF, 4'b0011, 3,  32'h12345678, 32'h0,        1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h00002004, 32'h0,        4'b1111, 1,  32'h0BADF00D, 32'h0BADF00D, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'hBFC00004, 32'h0,        4'b0000, 2,  32'h8C880000, 32'h8C880000, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'hBFC00008, 32'h0,        4'b0000, 10, 32'hFFFFFFFF, 32'h0,        1'b1};
    vecs[5] = '{1'b1, 1'b1, 32'h00003000, 32'hA5A55A5A, 4'b1100, 0,  32'h11111111, 32'h0,        1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'h00003008, 32'h0,        4'b0110, 4,  32'h22222222, 32'h0,        1'b1};

    reset = 1'b0;
    f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_byteenable = '0;
    waitrequest = 1'b0; readdata = '0;

    // Reset state
    @(negedge clk);
    chk("rst_rw", {30'd0, read, write}, 32'd0);
    chk("rst_addr", address, 32'd0);
    chk("rst_wdata", writedata, 32'd0);
    chk("rst_be", {28'd0, byteenable}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ack_err", {29'd0, f_ack, d_ack, err}, 32'd0);
    step();
    reset = 1'b1;

    // Table-driven single transfers
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Reset asserted mid-BUS: outputs drop immediately and the transfer is never acked
    step();
    f_req = 1'b1; f_addr = 32'hBFC00200; waitrequest = 1'b1;
    step();
    @(negedge clk);
    chk("midrst_read_before", {31'd0, read}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_read", {31'd0, read}, 32'd0);
    chk("midrst_addr", address, 32'd0);
    chk("midrst_ack", {30'd0, f_ack, d_ack}, 32'd0);
    f_req = 1'b0; waitrequest = 1'b0;
    step();
    step();
    reset = 1'b1;
    last_d = 1'b0;
    @(negedge clk);
    chk("midrst_idle_rw", {30'd0, read, write}, 32'd0);

    // Contention: both requests held for four transfers, then F alone
    step();
    f_req = 1'b1; f_addr = 32'hBFC00100;
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h00004000; d_byteenable = 4'b1111;
    waitrequest = 1'b0; readdata = 32'h600DCAFE;
    for (int t = 0; t < 4; t++) begin
      if (t > 0) step();                 // IDLE
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = !last_d;
`else
      exp_d = 1'b1;
`endif
      e.is_d = exp_d; e.rdata = 32'h600DCAFE; e.err = 1'b0;
      sb.push_back(e);
      step();                            // BUS
      @(negedge clk);
      chk($sformatf("cont%0d_addr", t), address, exp_d ? 32'h00004000 : 32'hBFC00100);
      step();                            // DONE
      if (t == 3) d_req = 1'b0;
      @(negedge clk);
      chk($sformatf("cont%0d_ack", t), {30'd0, f_ack, d_ack}, exp_d ? 32'd1 : 32'd2);
      last_d = exp_d;
    end
    step();                              // IDLE: only F left
    e.is_d = 1'b0; e.rdata = 32'h600DCAFE; e.err = 1'b0;
    sb.push_back(e);
    step();
    @(negedge clk);
    chk("cont_f_addr", address, 32'hBFC00100);
    step();
    f_req = 1'b0;
    @(negedge clk);
    chk("cont_f_ack", {30'd0, f_ack, d_ack}, 32'd2);
    last_d = 1'b0;

    // Back-to-back D loads with req held: one transfer every three cycles
    step();
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h00005000; d_byteenable = 4'b1111;
    waitrequest = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      readdata = 32'h70000000 + i;
      if (i % 3 == 0) begin
        e.is_d = 1'b1; e.rdata = 32'h70000000 + i + 1; e.err = 1'b0;
        sb.push_back(e);
      end
      if (i == 8) d_req = 1'b0;
      @(negedge clk);
      chk($sformatf("b2b_c%0d_ack", i), {30'd0, f_ack, d_ack}, (i % 3 == 2) ? 32'd1 : 32'd0);
    end

    // Quiet bus afterwards; every expected ack must have arrived
    step();
    step();
    @(negedge clk);
    chk("end_rw", {30'd0, read, write}, 32'd0);
    chk("end_pending", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
